// File: rtl/instr_sequencer_if.sv
// Bundles the instruction sequencer's program-word, ALU-status and decoded-control signals.
// master = core/memory side, slave = the sequencer itself.
interface instr_sequencer_if #(
  parameter int IW = 12,
  parameter int DW = 8
);
  logic [IW-1:0] prog_data;
  logic          alu_zero;
  logic          wake;
  logic [1:0]    q_phase;
  logic [IW-1:0] ir;
  logic          alu_mux_sel;
  logic [DW-1:0] irsta_bus;
  logic [4:0]    alu_op;
  logic [2:0]    bit_sel;
  logic [4:0]    ram_addr;
  logic [8:0]    pc_target;
  logic          w_we;
  logic          ram_we;
  logic          status_we;
  logic          pc_inc;
  logic          pc_load;
  logic          pc_push;
  logic          pc_pop;

  modport master (
    output prog_data, alu_zero, wake,
    input  q_phase, ir, alu_mux_sel, irsta_bus, alu_op, bit_sel, ram_addr, pc_target,
    input  w_we, ram_we, status_we, pc_inc, pc_load, pc_push, pc_pop
  );

  modport slave (
    input  prog_data, alu_zero, wake,
    output q_phase, ir, alu_mux_sel, irsta_bus, alu_op, bit_sel, ram_addr, pc_target,
    output w_we, ram_we, status_we, pc_inc, pc_load, pc_push, pc_pop
  );
endinterface

// File: rtl/instr_sequencer.sv
// PIC10F200 Q1..Q4 instruction sequencer and decoder; all control outputs are registered.
// Optional macro SLEEP_EN: SLEEP (12'h003) parks the sequencer in Q1 until wake.
module instr_sequencer #(
  parameter int IW = 12,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_sequencer_if.slave bus
);
  typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_e;

  typedef struct packed {
    logic       mux;
    logic [4:0] op;
    logic       w_we;
    logic       ram_we;
    logic       status_we;
    logic       pc_inc;
    logic       pc_load;
    logic       pc_push;
    logic       pc_pop;
  } ctl_t;

  function automatic ctl_t decode(input logic [IW-1:0] w, input logic noinc);
    ctl_t c;
    c = '0;
    unique case (w[11:10])
      2'b00: begin
        if (w[9:3] != '0) begin
          c.op        = {1'b0, w[9:6]};
          c.ram_we    = w[5];
          c.w_we      = ~w[5];
          c.status_we = !(w[9:6] inside {4'h0, 4'hB, 4'hE, 4'hF});
        end
      end
      2'b01: begin
        c.op     = (w[9:8] == 2'b00) ? 5'h14 : (w[9:8] == 2'b01) ? 5'h15 : 5'h16;
        c.ram_we = ~w[9];
      end
      2'b10: begin
        c.pc_load = w[9] | w[8];
        c.pc_push = (w[9:8] == 2'b01);
        if (w[9:8] == 2'b00) begin
          c.mux    = 1'b1;
          c.op     = 5'h10;
          c.w_we   = 1'b1;
          c.pc_pop = 1'b1;
        end
      end
      default: begin
        c.mux       = 1'b1;
        c.op        = {3'b100, w[9:8]};
        c.w_we      = 1'b1;
        c.status_we = (w[9:8] != 2'b00);
      end
    endcase
    // A NOP cycle that replaces a branch target fetch must not advance the PC again.
    c.pc_inc = (w[11:10] != 2'b10) && !noinc;
    return c;
  endfunction

  function automatic logic skip_hit(input logic [IW-1:0] w, input logic az);
    logic fsz;
    fsz = (w[11:10] == 2'b00) && ((w[9:6] == 4'hB) || (w[9:6] == 4'hF));
    return (fsz && az) || ((w[11:8] == 4'b0110) && az) || ((w[11:8] == 4'b0111) && !az);
  endfunction

  phase_e        phase_q, phase_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          flush_q, flush_d;
  logic          flbr_q, flbr_d;
  logic          noinc_q, noinc_d;
  logic          sleep_q, sleep_d;
  logic          hold;
  ctl_t          ctl_q, ctl_d;

  always_comb begin
    phase_d = phase_q;
    ir_d    = ir_q;
    flush_d = flush_q;
    flbr_d  = flbr_q;
    noinc_d = noinc_q;
    sleep_d = sleep_q;
    hold    = 1'b0;
`ifdef SLEEP_EN
    hold = sleep_q && !bus.wake;
    if (sleep_q && bus.wake) sleep_d = 1'b0;
`endif
    if (!hold) begin
      unique case (phase_q)
        Q1:      phase_d = Q2;
        Q2:      phase_d = Q3;
        Q3:      phase_d = Q4;
        default: phase_d = Q1;
      endcase
      if (phase_q == Q1) begin
        ir_d    = flush_q ? '0 : bus.prog_data;
        noinc_d = flbr_q;
        flush_d = 1'b0;
        flbr_d  = 1'b0;
      end
      if (phase_q == Q4) begin
        flbr_d  = (ir_q[11:10] == 2'b10);
        flush_d = (ir_q[11:10] == 2'b10) || skip_hit(ir_q, bus.alu_zero);
`ifdef SLEEP_EN
        sleep_d = (ir_q == 12'h003);
`endif
      end
    end
    // Outputs are precomputed for the phase being entered so they register cleanly.
    ctl_d = decode(ir_d, noinc_d);
    if (phase_d == Q1) begin
      ctl_d = '0;
    end else if (phase_d != Q4) begin
      ctl_d.w_we      = 1'b0;
      ctl_d.ram_we    = 1'b0;
      ctl_d.status_we = 1'b0;
      ctl_d.pc_inc    = 1'b0;
      ctl_d.pc_load   = 1'b0;
      ctl_d.pc_push   = 1'b0;
      ctl_d.pc_pop    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= Q1;
      ir_q    <= '0;
      flush_q <= 1'b0;
      flbr_q  <= 1'b0;
      noinc_q <= 1'b0;
      sleep_q <= 1'b0;
      ctl_q   <= '0;
    end else begin
      phase_q <= phase_d;
      ir_q    <= ir_d;
      flush_q <= flush_d;
      flbr_q  <= flbr_d;
      noinc_q <= noinc_d;
      sleep_q <= sleep_d;
      ctl_q   <= ctl_d;
    end
  end

`ifndef SLEEP_EN
  logic unused_wake;
  assign unused_wake = bus.wake;
`endif

  assign bus.q_phase     = phase_q;
  assign bus.ir          = ir_q;
  assign bus.irsta_bus   = ir_q[DW-1:0];
  assign bus.bit_sel     = ir_q[7:5];
  assign bus.ram_addr    = ir_q[4:0];
  assign bus.pc_target   = (ir_q[11:8] == 4'b1001) ? {1'b0, ir_q[7:0]} : ir_q[8:0];
  assign bus.alu_mux_sel = ctl_q.mux;
  assign bus.alu_op      = ctl_q.op;
  assign bus.w_we        = ctl_q.w_we;
  assign bus.ram_we      = ctl_q.ram_we;
  assign bus.status_we   = ctl_q.status_we;
  assign bus.pc_inc      = ctl_q.pc_inc;
  assign bus.pc_load     = ctl_q.pc_load;
  assign bus.pc_push     = ctl_q.pc_push;
  assign bus.pc_pop      = ctl_q.pc_pop;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed instruction checks plus randomized program words
// compared each cycle against an opcode-range behavioural model.
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic chk_en = 1'b0;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: phase number, latched word, pending flush kind (0 none, 1 skip, 2 branch).
  int         m_ph = 0;
  logic [11:0] m_ir = '0;
  int         m_pend = 0;
  logic       m_noinc = 1'b0;
  logic       m_sleep = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_stb();
    return {bus.w_we, bus.ram_we, bus.status_we, bus.pc_inc, bus.pc_load, bus.pc_push, bus.pc_pop};
  endfunction

  function automatic logic [26:0] core_vec();
    return {bus.q_phase, bus.ir, bus.alu_mux_sel, bus.alu_op, dut_stb()};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {12'h0, core_vec(), bus.irsta_bus, bus.bit_sel, bus.ram_addr, bus.pc_target};
  endfunction

  // Expected outputs from the instruction's opcode range; stb = {w,ram,status,inc,load,push,pop}.
  function automatic logic [63:0] model_out();
    int w, f, sub;
    logic mux, br;
    logic [4:0] op;
    logic [6:0] stb;
    logic [8:0] tgt;
    w = int'(m_ir);
    mux = 1'b0; br = 1'b0; op = '0; stb = '0;
    sub = (w / 256) % 4;
    if (w < 'h008) begin
      op = '0;
    end else if (w < 'h400) begin
      f = (w / 64) % 16;
      op = 5'(f);
      if ((w / 32) % 2 == 1) stb[5] = 1'b1; else stb[6] = 1'b1;
      stb[4] = !(f == 0 || f == 11 || f == 14 || f == 15);
    end else if (w < 'h800) begin
      op = 5'(20 + ((sub > 1) ? 2 : sub));
      stb[5] = (sub < 2);
    end else if (w < 'h900) begin
      mux = 1'b1; op = 5'h10; stb[6] = 1'b1; stb[0] = 1'b1; br = 1'b1;
    end else if (w < 'hA00) begin
      stb[2] = 1'b1; stb[1] = 1'b1; br = 1'b1;
    end else if (w < 'hC00) begin
      stb[2] = 1'b1; br = 1'b1;
    end else begin
      mux = 1'b1; op = 5'(16 + sub); stb[6] = 1'b1; stb[4] = (sub != 0);
    end
    stb[3] = !br && !m_noinc;
    if (m_ph == 0) begin mux = 1'b0; op = '0; end
    if (m_ph != 3) stb = '0;
    tgt = (w >= 'h900 && w < 'hA00) ? 9'(w % 256) : 9'(w % 512);
    return {12'h0, 2'(m_ph), m_ir, mux, op, stb, 8'(w % 256), 3'((w / 32) % 8), 5'(w % 32), tgt};
  endfunction

  task automatic model_step(input logic rst, input logic [11:0] pd, input logic az, input logic wk);
    int w;
    logic skip;
    if (!rst) begin
      m_ph = 0; m_ir = '0; m_pend = 0; m_noinc = 1'b0; m_sleep = 1'b0;
      return;
    end
    if (m_sleep) begin
      if (wk) begin
        m_sleep = 1'b0; m_ir = pd; m_noinc = 1'b0; m_ph = 1;
      end
      return;
    end
    case (m_ph)
      0: begin
        m_ir = (m_pend != 0) ? 12'h000 : pd;
        m_noinc = (m_pend == 2);
        m_pend = 0;
        m_ph = 1;
      end
      3: begin
        w = int'(m_ir);
        skip = ((w >= 'h2C0 && w < 'h300) || (w >= 'h3C0 && w < 'h400) || (w >= 'h600 && w < 'h700)) ? az :
               (w >= 'h700 && w < 'h800) ? !az : 1'b0;
        m_pend = (w >= 'h800 && w < 'hC00) ? 2 : (skip ? 1 : 0);
`ifdef SLEEP_EN
        m_sleep = (w == 'h003);
`endif
        m_ph = 0;
      end
      default: m_ph = m_ph + 1;
    endcase
  endtask

  task automatic tick(input logic rst, input logic [11:0] pd, input logic az, input logic wk);
    @(negedge clk);
    rst_n = rst;
    bus.prog_data = pd;
    bus.alu_zero = az;
    bus.wake = wk;
    model_step(rst, pd, az, wk);
    chk_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic tk(input logic [11:0] pd, input logic az);
    tick(1'b1, pd, az, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) chk("cycle", dut_vec(), model_out());
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.prog_data = '0;
    bus.alu_zero = 1'b0;
    bus.wake = 1'b0;
    repeat (3) tick(1'b0, 12'hC5A, 1'b0, 1'b0);
    chk("reset_state", 64'(core_vec()), 64'(0));

    // MOVLW 0x5A
    tk(12'hC5A, 1'b0);
    chk("release_q2", 64'(bus.q_phase), 64'(1));
    chk("movlw_fields", 64'({bus.alu_mux_sel, bus.alu_op, bus.irsta_bus}), 64'({1'b1, 5'h10, 8'h5A}));
    tk(12'hC5A, 1'b0); tk(12'hC5A, 1'b0);
    chk("movlw_q4", 64'(dut_stb()), 64'(7'b1001000));
    tk(12'hC5A, 1'b0);

    // ADDWF 0x10,1
    tk(12'h1F0, 1'b0);
    chk("addwf_fields", 64'({bus.alu_mux_sel, bus.alu_op, bus.ram_addr}), 64'({1'b0, 5'h07, 5'h10}));
    tk(12'h1F0, 1'b0); tk(12'h1F0, 1'b0);
    chk("addwf_q4", 64'(dut_stb()), 64'(7'b0111000));
    tk(12'h1F0, 1'b0);

    // GOTO 0x0A5, then the flushed slot
    repeat (3) tk(12'hAA5, 1'b0);
    chk("goto_q4", 64'({dut_stb(), bus.pc_target}), 64'({7'b0000100, 9'h0A5}));
    tk(12'hAA5, 1'b0);
    tk(12'hC5A, 1'b0);
    chk("goto_flush_ir", 64'(bus.ir), 64'(0));
    tk(12'hC5A, 1'b0); tk(12'hC5A, 1'b0);
    chk("goto_flush_q4", 64'(dut_stb()), 64'(0));
    tk(12'hC5A, 1'b0);

    // DECFSZ 0x08,1 with alu_zero=1 skips
    repeat (4) tk(12'h2E8, 1'b1);
    tk(12'hC11, 1'b0);
    chk("skip_ir", 64'(bus.ir), 64'(0));
    tk(12'hC11, 1'b0); tk(12'hC11, 1'b0);
    chk("skip_q4", 64'(dut_stb()), 64'(7'b0001000));
    tk(12'hC11, 1'b0);

    // DECFSZ with alu_zero=0 falls through
    repeat (4) tk(12'h2E8, 1'b0);
    tk(12'hC11, 1'b0);
    chk("noskip_ir", 64'(bus.ir), 64'(12'hC11));
    repeat (3) tk(12'hC11, 1'b0);

    // SLEEP
    repeat (3) tk(12'h003, 1'b0);
    chk("sleep_q4", 64'(dut_stb()), 64'(7'b0001000));
    tk(12'h003, 1'b0);
`ifdef SLEEP_EN
    for (int i = 0; i < 10; i++) begin
      tk(12'hC5A, 1'b0);
      chk("sleep_hold", 64'({bus.q_phase, dut_stb()}), 64'(0));
    end
    tick(1'b1, 12'hC5A, 1'b0, 1'b1);
    chk("wake_q2", 64'({bus.q_phase, bus.ir}), 64'({2'd1, 12'hC5A}));
`else
    tk(12'hC5A, 1'b0);
    chk("sleep_nop_next", 64'({bus.q_phase, bus.ir}), 64'({2'd1, 12'hC5A}));
`endif
    tk(12'hC5A, 1'b0); tk(12'hC5A, 1'b0); tk(12'hC5A, 1'b0);

    // Reset asserted in Q3 of an ADDWF
    tk(12'h1F0, 1'b0); tk(12'h1F0, 1'b0);
    tick(1'b0, 12'h1F0, 1'b0, 1'b0);
    chk("midreset", 64'(core_vec()), 64'(0));

    for (int i = 0; i < 3000; i++) begin
      logic [11:0] pd;
      int r;
      r = int'($urandom_range(0, 7));
      if (r < 4) begin
        pd = 12'($urandom);
      end else if (r < 6) begin
        case ($urandom_range(0, 3))
          0: pd = 12'h2C0;
          1: pd = 12'h3C0;
          2: pd = 12'h600;
          default: pd = 12'h700;
        endcase
        pd = pd | 12'($urandom_range(0, 63));
      end else begin
        pd = 12'($urandom_range(0, 15));
      end
      tick(($urandom_range(0, 99) != 0), pd, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
